// File: rtl/clk_div.sv
// clk_div: integer clock divider.
//
// Divides clk by DIV. Even ratios give 50% duty. Odd ratios give one cycle more low
// than high, unless CLK_DIV_ODD_DUTY50_EN is defined. With that macro, a falling-edge
// flop stretches the high phase by half a clk cycle so odd ratios also get 50% duty.
// DIV=1 passes clk straight through, gated low while in reset.
//
// Parameters:
//   DIV - divide ratio, 1..65535. Any other value is an elaboration error.
//   CW  - counter width. It is derived from DIV; do not override it.
// Ports:
//   clk   - input clock. State updates on the rising edge; the optional odd-duty flop
//           updates on the falling edge.
//   rst   - asynchronous, active-high reset. clk_d is low while rst is high.
//   clk_d - divided clock output.
// Optional feature macro: CLK_DIV_ODD_DUTY50_EN

module clk_div #(
  parameter int unsigned DIV = 2,
  parameter int unsigned CW  = $clog2(DIV) + 1
) (
  input  logic clk,
  input  logic rst,
  output logic clk_d
);

  if (DIV < 1 || DIV > 65535) begin : g_bad_div
    $error("clk_div: DIV=%0d is outside the legal range 1..65535", DIV);
  end

  if (DIV == 1) begin : g_bypass
    // No counter is needed. The output follows clk, held low during reset.
    assign clk_d = clk & ~rst;
  end else begin : g_div
    localparam logic [CW-1:0] MaxCnt   = CW'(DIV - 1);
    // Output is high for counter values at or above ceil(DIV/2).
    localparam logic [CW-1:0] HighFrom = CW'((DIV + 1) / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          p_q, p_d;

    always_comb begin
      cnt_d = (cnt_q == MaxCnt) ? '0 : cnt_q + 1'b1;
      // Compare against the post-wrap value so p_q is in step with cnt_q.
      p_d   = (cnt_d >= HighFrom);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        p_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        p_q   <= p_d;
      end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    if (DIV % 2 == 1) begin : g_odd_duty50
      logic n_q;

      // n_q follows p_q half a cycle later. OR-ing the two stretches the high phase
      // by half a cycle. The two flops switch on opposite clk edges, so the OR
      // cannot glitch.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          n_q <= 1'b0;
        end else begin
          n_q <= p_q;
        end
      end

      assign clk_d = p_q | n_q;
    end else begin : g_even
      assign clk_d = p_q;
    end
`else
    assign clk_d = p_q;
`endif
  end

endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: checks clk_div for DIV = 1..7 against a behavioural model.
// The stimulus process drives clk and a random reset. At each sample point it pushes
// the expected outputs into a queue. A separate monitor pops those values and
// compares them with the DUT outputs.

module tb_clk_div;

  localparam int NDut = 7;

`ifdef CLK_DIV_ODD_DUTY50_EN
  localparam bit OddDuty50 = 1'b1;
`else
  localparam bit OddDuty50 = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [NDut-1:0] clk_d_w;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    clk_div #(
      .DIV(g + 1)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .clk_d(clk_d_w[g])
    );
  end

  int              checks = 0;
  int              errors = 0;
  int              k      = 0;   // rising edges seen with rst low since last reset
  logic [NDut-1:0] exp_q[$];
  event            sample_ev;

  // Output level after kk counted edges: high for the upper ceil-half-excluded
  // portion of each DIV-cycle period.
  function automatic logic phase_high(int d, int kk);
    return (kk % d) >= ((d + 1) / 2);
  endfunction

  function automatic logic model(int d);
    logic v;
    if (rst) return 1'b0;
    if (d == 1) return clk;
    v = phase_high(d, k);
    // Odd-duty mode: during clk high the previous phase's level still holds.
    if (OddDuty50 && (d % 2 == 1) && clk && k > 0) v = v | phase_high(d, k - 1);
    return v;
  endfunction

  task automatic push_and_sample();
    logic [NDut-1:0] e;
    for (int i = 0; i < NDut; i++) e[i] = model(i + 1);
    exp_q.push_back(e);
    ->sample_ev;
  endtask

  // Monitor: compare DUT outputs with the queued expectations.
  initial begin
    logic [NDut-1:0] e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty at t=%0t: no expected value available", $time);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < NDut; i++) begin
          checks++;
          if (clk_d_w[i] !== e[i]) begin
            errors++;
            $display("FAIL div%0d_clk_d at t=%0t clk=%0b rst=%0b k=%0d: got %0b expected %0b",
                     i + 1, $time, clk, rst, k, clk_d_w[i], e[i]);
          end
        end
      end
    end
  end

  // Stimulus: half period 10. Samples land 3 and 8 units after each edge. rst only
  // changes at the midpoint, so it never coincides with a clk edge.
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    k   = 0;
    for (int h = 0; h < 1600; h++) begin
      clk = ~clk;
      if (clk && !rst) k++;
      #3;
      push_and_sample();
      #2;
      if (h == 3) begin
        rst = 1'b0;
      end else if (h == 901 || h == 1203) begin
        // Forced mid-period resets, in addition to the random ones.
        rst = 1'b1;
        k   = 0;
      end else if (h > 3) begin
        if (rst) begin
          if ($urandom_range(0, 2) == 0) rst = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          rst = 1'b1;
          k   = 0;
        end
      end
      #3;
      push_and_sample();
      #2;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, got t=%0t expected < 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
